// File: rtl/serial_twos_comp_mc.sv
// rtl/serial_twos_comp_mc.sv - multi-lane word-framed bit-serial two's-complement negator
// LSB-first serial negation per lane with framing, stall, restart and overflow reporting.
module serial_twos_comp_mc #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic             t_clk,
  input  logic             rn,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [LANES-1:0] in_bit,
  input  logic [LANES-1:0] neg_en,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [LANES-1:0] out_bit,
  output logic [LANES-1:0] ovf,
  output logic             frame_err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [LANES-1:0] seen_q, seen_d;
  logic [LANES-1:0] neg_lat_q, neg_lat_d;

  logic             sof_beat, accept, restart, last;
  logic [IW-1:0]    cur_idx;
  logic [LANES-1:0] neg_eff, seen_eff;
  logic [LANES-1:0] out_bit_d, ovf_d;

  always_comb begin
    sof_beat  = in_valid & in_sof;
    accept    = sof_beat | (in_valid & (state_q == RUN));
    restart   = sof_beat & (state_q == RUN) & (bit_idx_q != '0);
    cur_idx   = sof_beat ? '0 : bit_idx_q;
    last      = accept & (cur_idx == LAST_IDX);
    neg_eff   = sof_beat ? neg_en : neg_lat_q;
    seen_eff  = sof_beat ? '0 : seen_q;

    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    seen_d    = seen_q;
    neg_lat_d = neg_lat_q;
    if (accept) begin
      state_d   = last ? IDLE : RUN;
      bit_idx_d = last ? '0 : cur_idx + IW'(1);
      seen_d    = seen_eff | in_bit;
      neg_lat_d = neg_eff;
    end

    // Bits up to and including the first 1 pass; everything above it inverts.
    out_bit_d = accept ? (in_bit ^ (neg_eff & seen_eff)) : '0;
    // Only -2^(WIDTH-1) reaches the MSB as a 1 with no lower 1 seen.
    ovf_d     = last ? (neg_eff & in_bit & ~seen_eff) : '0;
  end

  always_ff @(posedge t_clk or negedge rn) begin
    if (!rn) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      seen_q    <= '0;
      neg_lat_q <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_bit   <= '0;
      ovf       <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      seen_q    <= seen_d;
      neg_lat_q <= neg_lat_d;
      out_valid <= accept;
      out_sof   <= sof_beat;
      out_eof   <= last;
      out_bit   <= out_bit_d;
      ovf       <= ovf_d;
      frame_err <= restart;
    end
  end

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// tb/tb_serial_twos_comp_mc.sv - directed and random frames checked against word-level negation
// Expected output bits are bit i of the arithmetic negation of each lane's whole word.
module tb_serial_twos_comp_mc;

  localparam int W = 8;
  localparam int L = 4;

  logic         t_clk = 1'b0;
  logic         rn;
  logic         in_valid;
  logic         in_sof;
  logic [L-1:0] in_bit;
  logic [L-1:0] neg_en;
  logic         out_valid;
  logic         out_sof;
  logic         out_eof;
  logic [L-1:0] out_bit;
  logic [L-1:0] ovf;
  logic         frame_err;

  int n_cmp = 0;
  int n_err = 0;

  serial_twos_comp_mc #(.WIDTH(W), .LANES(L)) dut (
    .t_clk    (t_clk),
    .rn       (rn),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_bit   (in_bit),
    .neg_en   (neg_en),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .out_bit  (out_bit),
    .ovf      (ovf),
    .frame_err(frame_err)
  );

  always #5 t_clk = ~t_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(0));
    chk({tag, ".sof"},   64'(out_sof),   64'(0));
    chk({tag, ".eof"},   64'(out_eof),   64'(0));
    chk({tag, ".bits"},  64'(out_bit),   64'(0));
    chk({tag, ".ovf"},   64'(ovf),       64'(0));
    chk({tag, ".ferr"},  64'(frame_err), 64'(0));
  endtask

  // Drive one beat, advance one clock, check the registered response.
  task automatic beat(input logic v, input logic sof, input logic [L-1:0] bits,
                      input logic [L-1:0] neg, input logic e_valid, input logic e_sof,
                      input logic e_eof, input logic [L-1:0] e_bits, input logic [L-1:0] e_ovf,
                      input logic e_ferr, input string tag);
    in_valid = v;
    in_sof   = sof;
    in_bit   = bits;
    neg_en   = neg;
    @(posedge t_clk);
    #1;
    chk({tag, ".valid"}, 64'(out_valid), 64'(e_valid));
    chk({tag, ".eof"},   64'(out_eof),   64'(e_eof));
    chk({tag, ".ovf"},   64'(ovf),       64'(e_ovf));
    chk({tag, ".ferr"},  64'(frame_err), 64'(e_ferr));
    if (e_valid) begin
      chk({tag, ".sof"},  64'(out_sof), 64'(e_sof));
      chk({tag, ".bits"}, 64'(out_bit), 64'(e_bits));
    end
  endtask

  task automatic stall_beat(input string tag);
    beat(1'b0, 1'($urandom), L'($urandom), L'($urandom), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, tag);
  endtask

  // Send nbits of a frame; stalls of length stall_nX are inserted after bit stall_atX.
  task automatic run_frame(input logic [L-1:0][W-1:0] words, input logic [L-1:0] neg,
                           input int nbits, input int stall_at0, input int stall_n0,
                           input int stall_at1, input int stall_n1, input bit restart,
                           input string tag);
    logic [L-1:0][W-1:0] res;
    logic [L-1:0]        ovfe;
    logic [L-1:0]        bits, ebits, negd;
    logic [W-1:0]        minval;
    int                  n;
    minval = '0;
    minval[W-1] = 1'b1;
    for (int l = 0; l < L; l++) begin
      res[l]  = neg[l] ? (W'(0) - words[l]) : words[l];
      ovfe[l] = neg[l] && (words[l] == minval);
    end
    for (int i = 0; i < nbits; i++) begin
      for (int l = 0; l < L; l++) begin
        bits[l]  = words[l][i];
        ebits[l] = res[l][i];
      end
      negd = (i == 0) ? neg : L'($urandom);
      beat(1'b1, i == 0, bits, negd, 1'b1, i == 0, i == W - 1, ebits,
           (i == W - 1) ? ovfe : '0, restart && (i == 0), tag);
      n = (i == stall_at0) ? stall_n0 : ((i == stall_at1) ? stall_n1 : 0);
      repeat (n) stall_beat({tag, "_stall"});
    end
  endtask

  initial begin
    logic [L-1:0][W-1:0] w;
    logic [L-1:0]        ng;
    rn       = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_bit   = '0;
    neg_en   = '0;
    #1;
    check_all_zero("reset_async");
    repeat (2) @(posedge t_clk);
    #1;
    check_all_zero("reset_held");
    rn = 1'b1;

    // Basic mix of negate/pass lanes.
    w = {8'h01, 8'h00, 8'h05, 8'h05};
    run_frame(w, 4'b1101, W, -1, 0, -1, 0, 1'b0, "t1");

    // Most-negative value overflows; 0x7F does not.
    w = {8'h00, 8'h00, 8'h7F, 8'h80};
    run_frame(w, 4'b0011, W, -1, 0, -1, 0, 1'b0, "t2");

    // Stalls after bit 2 (3 cycles) and bit 5 (1 cycle).
    w = {8'hA5, 8'h80, 8'hFF, 8'h34};
    run_frame(w, 4'b0101, W, 2, 3, 5, 1, 1'b0, "t3");

    // Back-to-back, neg_en toggled between frames.
    w = {8'h10, 8'h10, 8'h10, 8'h10};
    run_frame(w, 4'b0001, W, -1, 0, -1, 0, 1'b0, "t4a");
    run_frame(w, 4'b1110, W, -1, 0, -1, 0, 1'b0, "t4b");

    // Non-sof beats in IDLE are dropped.
    repeat (3) beat(1'b1, 1'b0, L'($urandom), L'($urandom), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "t5_idle");
    // Restart at bit 4.
    w = {8'hC3, 8'h80, 8'h01, 8'h7E};
    run_frame(w, 4'b1111, 4, -1, 0, -1, 0, 1'b0, "t5a");
    w = {8'h80, 8'h5A, 8'h00, 8'h34};
    run_frame(w, 4'b1011, W, -1, 0, -1, 0, 1'b1, "t5b");

    // Asynchronous reset mid-frame.
    w = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(w, 4'b1111, 3, -1, 0, -1, 0, 1'b0, "t6a");
    rn = 1'b0;
    #1;
    check_all_zero("t6_rst");
    @(negedge t_clk);
    rn = 1'b1;
    @(posedge t_clk);
    #1;
    check_all_zero("t6_post");
    beat(1'b1, 1'b0, '1, '1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "t6_idle");
    w = {8'h80, 8'h7F, 8'h02, 8'h02};
    run_frame(w, 4'b1101, W, -1, 0, -1, 0, 1'b0, "t6b");

    // Random frames with edge values, stalls, gaps and occasional restarts.
    for (int f = 0; f < 40; f++) begin
      for (int l = 0; l < L; l++) begin
        case ($urandom_range(0, 7))
          0:       w[l] = 8'h80;
          1:       w[l] = 8'h00;
          default: w[l] = W'($urandom);
        endcase
      end
      ng = L'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        run_frame(w, ng, $urandom_range(1, W - 1), -1, 0, -1, 0, 1'b0, "rnd_trunc");
        run_frame(w, ~ng, W, $urandom_range(0, W - 1), $urandom_range(0, 2), -1, 0, 1'b1, "rnd_restart");
      end else begin
        run_frame(w, ng, W, $urandom_range(0, W - 1), $urandom_range(0, 3),
                  $urandom_range(0, W - 1), $urandom_range(0, 1), 1'b0, "rnd");
      end
      repeat ($urandom_range(0, 1)) stall_beat("rnd_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_twos_comp_mc.md
Name: serial_twos_comp_mc

Overview:
- Multi-lane, word-framed, bit-serial two's-complement negator.
- LANES independent serial streams share one frame counter; each lane either passes its word through or negates it, selectable per frame.
- Words arrive LSB-first, WIDTH bits per frame, under an in_valid qualifier.
- Sits between serial sample sources and serial arithmetic consumers; it adds framing, stall and overflow reporting to the single-lane serial complementer.

Parameters:
- WIDTH, 8: bits per word/frame; legal range 2..64.
- LANES, 4: number of parallel serial lanes; legal range 1..32.

Ports:
- t_clk  input  1  clock; all state updates on the rising edge.
- rn  input  1  reset; asynchronous, active-low.
- in_valid  input  1  qualifies in_bit/in_sof this cycle; low = stall.
- in_sof  input  1  start of frame; marks bit 0 (LSB) of a new word; meaningful only when in_valid=1.
- in_bit  input  LANES  serial data, one bit per lane.
- neg_en  input  LANES  per-lane negate select; sampled only on an accepted in_sof beat and held for the frame.
- out_valid  output  1  output beat valid.
- out_sof  output  1  marks output bit 0.
- out_eof  output  1  marks output bit WIDTH-1 (MSB).
- out_bit  output  LANES  serial result, one bit per lane.
- ovf  output  LANES  per-lane overflow; valid only with out_eof.
- frame_err  output  1  one-cycle pulse on frame restart or truncation.

Behaviour:
- Reset (rn=0, asynchronous):
  - All outputs go to 0.
  - FSM goes to IDLE; bit counter, seen flags and latched neg_en all clear.
  - Reset mid-frame abandons the frame. No eof or ovf is emitted for it.
- FSM states: IDLE, RUN. bit_idx counts 0..WIDTH-1, width clog2(WIDTH).
- IDLE:
  - A beat with in_valid=1 and in_sof=1 is accepted as bit 0 and moves the FSM to RUN.
  - Beats with in_valid=1 and in_sof=0 are dropped: no output, no error.
- RUN:
  - Each in_valid=1 beat advances bit_idx.
  - An in_valid=0 beat holds all state and drives out_valid=0 the next cycle.
  - The beat with bit_idx=WIDTH-1 returns the FSM to IDLE.
- Back-to-back frames: an in_sof beat on the cycle after the last bit is accepted with no bubble.
- Mid-frame restart: in_sof=1 with in_valid=1 while in RUN and bit_idx≠0 does the following.
  - Restarts the frame: the beat is treated as bit 0 and neg_en is relatched.
  - Pulses frame_err for one cycle, aligned with that beat's output.
  - The truncated frame gets no out_eof and no ovf.
- Per-lane datapath, per accepted beat:
  - seen_eff = (bit 0 beat) ? 0 : seen.
  - out_bit = in_bit XOR (neg_lat AND seen_eff).
  - seen <= seen_eff OR in_bit.
  - Pass lanes (neg_lat=0) copy in_bit unchanged.
- Overflow: on bit WIDTH-1, ovf[l] = neg_lat AND in_bit AND NOT seen_eff. This detects negation of -2^(WIDTH-1); the output word equals the input in that case.
- Latency and alignment:
  - All outputs are registered with 1-cycle latency from the accepted beat.
  - out_valid, out_sof and out_eof align with their out_bit.
  - ovf and frame_err are 0 on every cycle where they are not asserted as defined above.

Test Plan:
1. WIDTH=8, LANES=4; lane0 neg=1 with 0x05, lane1 neg=0 with 0x05, lane2 neg=1 with 0x00, lane3 neg=1 with 0x01, all frames contiguous -> out words 0xFB, 0x05, 0x00, 0xFF; out_sof on first beat, out_eof on 8th, ovf=0000; first output 1 cycle after first beat.
2. lane0 neg=1 with 0x80, lane1 neg=1 with 0x7F -> out 0x80 with ovf[0]=1 at eof; out 0x81 with ovf[1]=0.
3. Negate 0x34 with in_valid low for 3 cycles after bit 2 and 1 cycle after bit 5 -> out word 0xCC; out_valid low for exactly the stalled cycles; eof on the 8th valid beat.
4. Two frames back-to-back, second with neg_en toggled (0x10 negated, then 0x10 passed) -> 0xF0 then 0x10; no idle cycle; out_sof on output beats 0 and 8.
5. in_sof reasserted at bit 4 of a frame -> frame_err pulse aligned with that beat's output; no eof for the aborted frame; the new frame completes correctly. in_valid beats without sof in IDLE -> no output.
6. rn asserted at bit 3 mid-frame -> outputs 0 immediately; after release, a fresh frame negating 0x02 yields 0xFE with no stale seen state.
